// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage. Owns the PC, issues word requests
//                to instruction memory (req/ready + rvalid, in order, at most
//                one outstanding) and buffers returned instructions in a
//                2-entry queue presented to decode. Holds on stall_IF and
//                squashes in-flight work on an EX-stage redirect.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RESET_PC          first fetch address after reset
//    NOP_INSTR         instruction shown on instr_IF while the queue is empty
//  Ports
//    clk               rising-edge clock
//    rst_n             asynchronous active-low reset
//    stall_IF          hazard hold, queue head is not consumed
//    redirect_EX       taken branch/jump resolved in EX
//    redirectTarget_EX new PC for the redirect
//    imem_req          fetch request
//    imem_addr         word address of the request ([1:0] = 00)
//    imem_ready        request accepted this cycle
//    imem_rvalid       response valid
//    imem_rdata        response instruction
//    valid_IF          queue head valid
//    instr_IF          queue head instruction
//    PC_IF             queue head PC (fetch PC while the queue is empty)
//    PCPlus4_IF        PC_IF + 4, modulo 2^32
//    misaligned_IF     (FETCH_MISALIGN_CHECK_EN only) sticky flag raised by a
//                      redirect to a target with [1:0] != 00
//  Build option
//    FETCH_MISALIGN_CHECK_EN  when defined, misaligned redirects raise
//                             misaligned_IF and freeze fetch until the next
//                             aligned redirect; otherwise target [1:0] is
//                             silently cleared.
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_IF,
    input  logic        redirect_EX,
    input  logic [31:0] redirectTarget_EX,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid_IF,
    output logic [31:0] instr_IF,
    output logic [31:0] PC_IF,
    output logic [31:0] PCPlus4_IF
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misaligned_IF
`endif
);

    // Request-tracking FSM
    localparam logic [1:0] c_idle = 2'd0;  // nothing outstanding
    localparam logic [1:0] c_wait = 2'd1;  // outstanding response will be kept
    localparam logic [1:0] c_drop = 2'd2;  // outstanding response will be discarded

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_req_addr;

    // Two-entry queue: slot 0 is always the head
    logic [1:0]  r_count;
    logic [1:0]  w_count_next;
    logic [31:0] r_instr0;
    logic [31:0] r_instr1;
    logic [31:0] r_pc0;
    logic [31:0] r_pc1;

    logic        w_outstanding;
    logic        w_keep;
    logic        w_pop;
    logic        w_accept;
    logic        w_wr_slot1;
    logic [2:0]  w_count_pre;
    logic [2:0]  w_count_need;
    logic        w_misaligned;

    // ------------------------------------------------------------------------
    // Misaligned-redirect tracking
    // ------------------------------------------------------------------------
`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misaligned <= 1'b0;
        end else if (redirect_EX) begin
            r_misaligned <= |redirectTarget_EX[1:0];
        end
    end

    assign w_misaligned  = r_misaligned;
    assign misaligned_IF = r_misaligned;
`else
    // Low target bits are dropped without comment in this build.
    logic w_unused_tgt_lsb;
    assign w_unused_tgt_lsb = ^redirectTarget_EX[1:0];
    assign w_misaligned     = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Issue logic
    // ------------------------------------------------------------------------
    assign w_outstanding = (r_state != c_idle);

    // A response is kept only in WAIT and only if no redirect squashes it.
    assign w_keep = (r_state == c_wait) & imem_rvalid & !redirect_EX;

    assign w_pop  = valid_IF & !stall_IF & !redirect_EX;

    // Queue occupancy after this cycle's push/pop, before any new request.
    assign w_count_pre  = {1'b0, r_count} + {2'b00, w_keep} - {2'b00, w_pop};
    // Room must also be reserved for a response still in flight.
    assign w_count_need = w_count_pre + {2'b00, (w_outstanding & !imem_rvalid)};

    // A new request may only go out when nothing is outstanding or the
    // outstanding response retires this same cycle, which keeps the memory
    // interface at one outstanding transaction.
    assign imem_req  = rst_n
                     & !redirect_EX
                     & !w_misaligned
                     & ((r_state == c_idle) | imem_rvalid)
                     & (w_count_need < 3'd2);
    assign imem_addr = r_pc;
    assign w_accept  = imem_req & imem_ready;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (redirect_EX) begin
            // A response arriving in the redirect cycle is simply discarded.
            w_state_next = (w_outstanding & !imem_rvalid) ? c_drop : c_idle;
        end else if (w_accept) begin
            w_state_next = c_wait;
        end else if (w_outstanding & imem_rvalid) begin
            w_state_next = c_idle;
        end
    end

    always_comb begin
        w_pc_next = r_pc;
        if (redirect_EX) begin
            w_pc_next = {redirectTarget_EX[31:2], 2'b00};
        end else if (w_accept) begin
            w_pc_next = r_pc + 32'd4;
        end
    end

    always_comb begin
        w_count_next = w_count_pre[1:0];
        if (redirect_EX) begin
            w_count_next = 2'd0;
        end
    end

    // Incoming entry lands behind whatever remains after the pop.
    assign w_wr_slot1 = (r_count == 2'd2) | ((r_count == 2'd1) & !w_pop);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_idle;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_accept) begin
                r_req_addr <= r_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= 2'd0;
            r_instr0 <= NOP_INSTR;
            r_instr1 <= NOP_INSTR;
            r_pc0    <= RESET_PC;
            r_pc1    <= RESET_PC;
        end else begin
            r_count <= w_count_next;
            if (!redirect_EX) begin
                if (w_pop) begin
                    r_instr0 <= r_instr1;
                    r_pc0    <= r_pc1;
                end
                // Later assignment wins over the shift when the new entry
                // becomes the head.
                if (w_keep) begin
                    if (w_wr_slot1) begin
                        r_instr1 <= imem_rdata;
                        r_pc1    <= r_req_addr;
                    end else begin
                        r_instr0 <= imem_rdata;
                        r_pc0    <= r_req_addr;
                    end
                end
            end
        end
    end

    // Issue gating guarantees the queue can never overflow.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_keep && !w_pop && (r_count == 2'd2)));

    // ------------------------------------------------------------------------
    // Decode-facing outputs
    // ------------------------------------------------------------------------
    assign valid_IF   = (r_count != 2'd0) & !w_misaligned;
    assign instr_IF   = valid_IF ? r_instr0 : NOP_INSTR;
    assign PC_IF      = valid_IF ? r_pc0 : r_pc;
    assign PCPlus4_IF = PC_IF + 32'd4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed, table-driven bench for fetch_stage with a small
//                instruction-memory responder (programmable latency/ready).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_IF;
    logic        redirect_EX;
    logic [31:0] redirectTarget_EX;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid_IF;
    logic [31:0] instr_IF;
    logic [31:0] PC_IF;
    logic [31:0] PCPlus4_IF;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misaligned_IF;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage #(
        .RESET_PC  (32'h0000_0100),
        .NOP_INSTR (NOP)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_IF          (stall_IF),
        .redirect_EX       (redirect_EX),
        .redirectTarget_EX (redirectTarget_EX),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rvalid       (imem_rvalid),
        .imem_rdata        (imem_rdata),
        .valid_IF          (valid_IF),
        .instr_IF          (instr_IF),
        .PC_IF             (PC_IF),
        .PCPlus4_IF        (PCPlus4_IF)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misaligned_IF     (misaligned_IF)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Memory responder state and knobs
    logic        rst_knob = 1'b0;
    logic        rdy_knob = 1'b1;
    int          lat      = 1;
    logic        pend     = 1'b0;
    int          cnt      = 0;
    logic [31:0] paddr    = 32'h0;

    // Samples taken 1 time unit after the inputs change
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_instr;
    logic [31:0] s_pc;
    logic [31:0] s_pc4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h1000_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs at negedge, model memory, sample outputs.
    task automatic step(input logic st, input logic rd, input logic [31:0] tgt);
        @(negedge clk);
        rst_n             = rst_knob;
        stall_IF          = st;
        redirect_EX       = rd;
        redirectTarget_EX = tgt;
        imem_ready        = rdy_knob;
        imem_rvalid       = 1'b0;
        imem_rdata        = 32'hDEAD_BEEF;
        if (pend) begin
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(paddr);
                pend        = 1'b0;
            end else begin
                cnt--;
            end
        end
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = valid_IF;
        s_instr = instr_IF;
        s_pc    = PC_IF;
        s_pc4   = PCPlus4_IF;
        if (s_req && imem_ready) begin
            pend  = 1'b1;
            paddr = s_addr;
            cnt   = lat - 1;
        end
        cyc++;
    endtask

    task automatic reset_dut();
        rst_knob = 1'b0;
        pend     = 1'b0;
        rdy_knob = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        rst_knob = 1'b1;
    endtask

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] tgt;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_req;
        int first_vld;

        rst_n = 1'b0; stall_IF = 1'b0; redirect_EX = 1'b0; redirectTarget_EX = 32'h0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;

        // Reset release, zero-wait memory, 4-cycle stall at head 0x104, release.
        //          st    rd    tgt    rdy   | req   addr         vld   pc
        tbl[0] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h100};
        tbl[1] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 1'b0, 32'h104};
        tbl[2] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
        tbl[3] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104};
        tbl[4] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104};
        tbl[5] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104};
        tbl[6] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104};
        tbl[7] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
        tbl[8] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h110, 1'b1, 32'h108};
        tbl[9] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h114, 1'b1, 32'h10C};

        // ---- reset values ----
        lat = 1;
        reset_dut();
        chk("rst_valid", {31'h0, s_valid}, 32'h0);
        chk("rst_instr", s_instr, NOP);
        chk("rst_pc",    s_pc,    32'h100);
        chk("rst_pc4",   s_pc4,   32'h104);
        chk("rst_req",   {31'h0, s_req}, 32'h0);

        // ---- table: startup, stall, release ----
        for (int i = 0; i < 10; i++) begin
            rdy_knob = tbl[i].rdy;
            step(tbl[i].st, tbl[i].rd, tbl[i].tgt);
            chk($sformatf("tbl%0d_req", i), {31'h0, s_req}, {31'h0, tbl[i].req});
            if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), {31'h0, s_valid}, {31'h0, tbl[i].vld});
            chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].pc);
            chk($sformatf("tbl%0d_pc4", i), s_pc4, tbl[i].pc + 32'd4);
            chk($sformatf("tbl%0d_instr", i), s_instr, tbl[i].vld ? mem_word(tbl[i].pc) : NOP);
        end

        // ---- redirect while 0x10C outstanding, 3-cycle latency ----
        reset_dut();
        lat = 3;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
        chk("seq3_setup_addr", s_req ? s_addr : 32'hFFFF_FFFF, 32'h10C);
        step(1'b0, 1'b1, 32'h200);
        chk("seq3_redir_req", {31'h0, s_req}, 32'h0);
        first_req = 0;
        first_vld = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b0, 32'h0);
            if (first_req == 0 && s_req) begin
                first_req = k;
                chk("seq3_req_addr", s_addr, 32'h200);
            end
            if (first_vld == 0 && s_valid) begin
                first_vld = k;
                chk("seq3_first_pc", s_pc, 32'h200);
                chk("seq3_first_instr", s_instr, mem_word(32'h200));
            end
        end
        chk("seq3_req_cycle",   first_req, 32'd2);
        chk("seq3_valid_cycle", first_vld, 32'd6);

        // ---- redirect coinciding with rvalid and stall ----
        reset_dut();
        lat = 1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h200);
        chk("seq4_redir_req", {31'h0, s_req}, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("seq4_valid0", {31'h0, s_valid}, 32'h0);
        chk("seq4_req",    {31'h0, s_req}, 32'h1);
        chk("seq4_addr",   s_addr, 32'h200);
        chk("seq4_pc",     s_pc,   32'h200);
        step(1'b1, 1'b0, 32'h0);
        chk("seq4_valid1", {31'h0, s_valid}, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("seq4_valid2", {31'h0, s_valid}, 32'h1);
        chk("seq4_head",   s_pc, 32'h200);

        // ---- ready held low, then wrap at 0xFFFF_FFFC ----
        reset_dut();
        lat = 1;
        rdy_knob = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0);
            chk($sformatf("seq5_hold%0d_addr", i), s_req ? s_addr : 32'hFFFF_FFFF, 32'h100);
            chk($sformatf("seq5_hold%0d_pc", i), s_pc, 32'h100);
        end
        rdy_knob = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("seq5_redir_req", {31'h0, s_req}, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("seq5_drop_valid", {31'h0, s_valid}, 32'h0);
        chk("seq5_top_addr", s_req ? s_addr : 32'h1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("seq5_wrap_addr", s_req ? s_addr : 32'h1, 32'h0000_0000);
        step(1'b0, 1'b0, 32'h0);
        chk("seq5_top_pc",  s_pc,  32'hFFFF_FFFC);
        chk("seq5_top_pc4", s_pc4, 32'h0000_0000);
        step(1'b0, 1'b0, 32'h0);
        chk("seq5_wrap_pc", s_valid ? s_pc : 32'h1, 32'h0000_0000);

        // ---- reset mid-transfer, late rvalid ignored ----
        reset_dut();
        lat = 4;
        step(1'b0, 1'b0, 32'h0);
        rst_knob = 1'b0;
        step(1'b0, 1'b0, 32'h0);
        chk("seq6_rst_req",   {31'h0, s_req},   32'h0);
        chk("seq6_rst_valid", {31'h0, s_valid}, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        rst_knob = 1'b1;
        rdy_knob = 1'b0;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("seq6_late_rvalid_seen", {31'h0, imem_rvalid}, 32'h1);
        lat = 1;
        rdy_knob = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        chk("seq6_ignored_valid", {31'h0, s_valid}, 32'h0);
        chk("seq6_addr", s_req ? s_addr : 32'h1, 32'h100);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("seq6_pc",    s_valid ? s_pc : 32'h1, 32'h100);
        chk("seq6_instr", s_instr, mem_word(32'h100));

`ifdef FETCH_MISALIGN_CHECK_EN
        // ---- misaligned redirect ----
        reset_dut();
        lat = 1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h202);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0);
            chk($sformatf("mis%0d_flag", i),  {31'h0, misaligned_IF}, 32'h1);
            chk($sformatf("mis%0d_req", i),   {31'h0, s_req},   32'h0);
            chk($sformatf("mis%0d_valid", i), {31'h0, s_valid}, 32'h0);
        end
        step(1'b0, 1'b1, 32'h300);
        step(1'b0, 1'b0, 32'h0);
        chk("mis_clear_flag", {31'h0, misaligned_IF}, 32'h0);
        chk("mis_resume_addr", s_req ? s_addr : 32'h1, 32'h300);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("mis_resume_pc", s_valid ? s_pc : 32'h1, 32'h300);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
